// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the pipelined MIPS core.
//   DATA_W / REG_AW / ALUOP_W : datapath, register-index and ALU-opcode widths
//   REG_ZERO                  : index of the hard-wired zero register
//   alu_op_e                  : ALU opcode encodings carried down the pipeline
package cpu_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: priority operand-forwarding mux for one source operand.
//   src_i        source register index read by decode
//   rf_data_i    register-file read data for src_i
//   ex_en_i      EX result is forwardable (valid, writes a reg, not a load)
//   ex_rw_i      EX destination index,  ex_data_i  EX combinational result
//   mem_en_i     MEM write enable,      mem_rw_i / mem_data_i
//   wb_en_i      WB write enable,       wb_rw_i  / wb_data_i
//   op_o         final operand value (youngest producer wins, r0 reads 0)
module fwd_mux #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              ex_en_i,
  input  logic [REG_AW-1:0] ex_rw_i,
  input  logic [DATA_W-1:0] ex_data_i,
  input  logic              mem_en_i,
  input  logic [REG_AW-1:0] mem_rw_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_rw_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] op_o
);

  always_comb begin
    op_o = rf_data_i;
    // r0 is hard-wired: any in-flight "write" to it must be ignored.
    if (src_i == '0) begin
      op_o = '0;
    end else if (ex_en_i && (ex_rw_i == src_i)) begin
      op_o = ex_data_i;
    end else if (mem_en_i && (mem_rw_i == src_i)) begin
      op_o = mem_data_i;
    end else if (wb_en_i && (wb_rw_i == src_i)) begin
      // The register file updates on the same edge that captures this
      // operand, so its read port still shows the stale value.
      op_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, load-use
// stall detection and branch flush.
//   clk, rst                      clock, async active-high reset
//   id_*                          decode-stage instruction fields and reg reads
//   ex_result                     combinational ALU result of the EX instruction
//   mem_regwr/mem_rw/mem_data     MEM-stage write-back info (forward source)
//   wb_regwr/wb_rw/wb_data        WB-stage write-back info (forward source)
//   flush                         discard the instruction in decode
//   stall_id                      hold PC and IF/ID (load-use hazard)
//   ex_*                          registered instruction seen by execute
module id_ex_stage #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int REG_AW  = cpu_pkg::REG_AW,
  parameter int ALUOP_W = cpu_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_ra,
  input  logic [REG_AW-1:0]  id_rb,
  input  logic               id_use_ra,
  input  logic               id_use_rb,
  input  logic [REG_AW-1:0]  id_rw,
  input  logic [DATA_W-1:0]  id_busa,
  input  logic [DATA_W-1:0]  id_busb,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_regwr,
  input  logic               id_memrd,
  input  logic               id_memwr,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic               mem_regwr,
  input  logic [REG_AW-1:0]  mem_rw,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic               wb_regwr,
  input  logic [REG_AW-1:0]  wb_rw,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  output logic               stall_id,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_opa,
  output logic [DATA_W-1:0]  ex_opb,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [REG_AW-1:0]  ex_rw,
  output logic               ex_regwr,
  output logic               ex_memrd,
  output logic               ex_memwr,
  output logic [ALUOP_W-1:0] ex_alu_op
);

  import cpu_pkg::*;

  logic               valid_q,  valid_d;
  logic [DATA_W-1:0]  opa_q,    opa_d;
  logic [DATA_W-1:0]  opb_q,    opb_d;
  logic [DATA_W-1:0]  imm_q,    imm_d;
  logic [REG_AW-1:0]  rw_q,     rw_d;
  logic               regwr_q,  regwr_d;
  logic               memrd_q,  memrd_d;
  logic               memwr_q,  memwr_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;

  logic              ex_fwd_en;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic              load_use;
  logic              capture;

  // A load's data is not known until MEM, so EX may only forward ALU results.
  assign ex_fwd_en = valid_q & regwr_q & ~memrd_q;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .src_i(id_ra), .rf_data_i(id_busa),
    .ex_en_i(ex_fwd_en), .ex_rw_i(rw_q), .ex_data_i(ex_result),
    .mem_en_i(mem_regwr), .mem_rw_i(mem_rw), .mem_data_i(mem_data),
    .wb_en_i(wb_regwr), .wb_rw_i(wb_rw), .wb_data_i(wb_data),
    .op_o(fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .src_i(id_rb), .rf_data_i(id_busb),
    .ex_en_i(ex_fwd_en), .ex_rw_i(rw_q), .ex_data_i(ex_result),
    .mem_en_i(mem_regwr), .mem_rw_i(mem_rw), .mem_data_i(mem_data),
    .wb_en_i(wb_regwr), .wb_rw_i(wb_rw), .wb_data_i(wb_data),
    .op_o(fwd_b)
  );

  assign load_use = valid_q & memrd_q & (rw_q != REG_ZERO) &
                    ((id_use_ra & (rw_q == id_ra)) | (id_use_rb & (rw_q == id_rb)));

  // A flushed instruction is discarded anyway, so it must not also stall.
  assign stall_id = load_use & id_valid & ~flush;
  assign capture  = id_valid & ~flush & ~stall_id;

  // Anything not captured becomes an all-zero bubble, so no regwr/memwr leaks.
  always_comb begin
    valid_d  = 1'b0;
    opa_d    = '0;
    opb_d    = '0;
    imm_d    = '0;
    rw_d     = '0;
    regwr_d  = 1'b0;
    memrd_d  = 1'b0;
    memwr_d  = 1'b0;
    alu_op_d = '0;
    if (capture) begin
      valid_d  = 1'b1;
      opa_d    = fwd_a;
      opb_d    = fwd_b;
      imm_d    = id_imm;
      rw_d     = id_rw;
      regwr_d  = id_regwr;
      memrd_d  = id_memrd;
      memwr_d  = id_memwr;
      alu_op_d = id_alu_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      imm_q    <= '0;
      rw_q     <= '0;
      regwr_q  <= 1'b0;
      memrd_q  <= 1'b0;
      memwr_q  <= 1'b0;
      alu_op_q <= '0;
    end else begin
      valid_q  <= valid_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      imm_q    <= imm_d;
      rw_q     <= rw_d;
      regwr_q  <= regwr_d;
      memrd_q  <= memrd_d;
      memwr_q  <= memwr_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign ex_valid  = valid_q;
  assign ex_opa    = opa_q;
  assign ex_opb    = opb_q;
  assign ex_imm    = imm_q;
  assign ex_rw     = rw_q;
  assign ex_regwr  = regwr_q;
  assign ex_memrd  = memrd_q;
  assign ex_memwr  = memwr_q;
  assign ex_alu_op = alu_op_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_ra, id_rb, id_rw;
  logic        id_use_ra, id_use_rb;
  logic [31:0] id_busa, id_busb, id_imm;
  logic        id_regwr, id_memrd, id_memwr;
  logic [3:0]  id_alu_op;
  logic [31:0] ex_result;
  logic        mem_regwr;
  logic [4:0]  mem_rw;
  logic [31:0] mem_data;
  logic        wb_regwr;
  logic [4:0]  wb_rw;
  logic [31:0] wb_data;
  logic        flush;
  logic        stall_id;
  logic        ex_valid;
  logic [31:0] ex_opa, ex_opb, ex_imm;
  logic [4:0]  ex_rw;
  logic        ex_regwr, ex_memrd, ex_memwr;
  logic [3:0]  ex_alu_op;

  int total = 0;
  int bad   = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_rw(id_rw),
    .id_busa(id_busa), .id_busb(id_busb), .id_imm(id_imm),
    .id_regwr(id_regwr), .id_memrd(id_memrd), .id_memwr(id_memwr),
    .id_alu_op(id_alu_op), .ex_result(ex_result),
    .mem_regwr(mem_regwr), .mem_rw(mem_rw), .mem_data(mem_data),
    .wb_regwr(wb_regwr), .wb_rw(wb_rw), .wb_data(wb_data),
    .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_imm(ex_imm), .ex_rw(ex_rw),
    .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr),
    .ex_alu_op(ex_alu_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vld;
    logic [4:0]  ra, rb;
    logic        ua, ub;
    logic [4:0]  rw;
    logic [31:0] busa, busb, imm;
    logic        regwr, memrd, memwr;
    logic [3:0]  op;
    logic [31:0] exres;
    logic        mwr;
    logic [4:0]  mrw;
    logic [31:0] mdata;
    logic        wwr;
    logic [4:0]  wrw;
    logic [31:0] wdata;
    logic        fl;
    logic        e_stall, e_vld;
    logic [31:0] e_opa, e_opb;
  } vec_t;

  localparam int NV = 13;
  vec_t vt[NV];

  function automatic vec_t mk(
    input logic [31:0] vld, ra, rb, ua, ub, rw, busa, busb, imm,
    input logic [31:0] regwr, memrd, memwr, op, exres,
    input logic [31:0] mwr, mrw, mdata, wwr, wrw, wdata, fl,
    input logic [31:0] e_stall, e_vld, e_opa, e_opb);
    vec_t r;
    r.vld = vld[0];   r.ra = ra[4:0];   r.rb = rb[4:0];
    r.ua = ua[0];     r.ub = ub[0];     r.rw = rw[4:0];
    r.busa = busa;    r.busb = busb;    r.imm = imm;
    r.regwr = regwr[0]; r.memrd = memrd[0]; r.memwr = memwr[0];
    r.op = op[3:0];   r.exres = exres;
    r.mwr = mwr[0];   r.mrw = mrw[4:0]; r.mdata = mdata;
    r.wwr = wwr[0];   r.wrw = wrw[4:0]; r.wdata = wdata;
    r.fl = fl[0];
    r.e_stall = e_stall[0]; r.e_vld = e_vld[0];
    r.e_opa = e_opa;  r.e_opb = e_opb;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    id_valid  = v.vld;   id_ra = v.ra;       id_rb = v.rb;
    id_use_ra = v.ua;    id_use_rb = v.ub;   id_rw = v.rw;
    id_busa   = v.busa;  id_busb = v.busb;   id_imm = v.imm;
    id_regwr  = v.regwr; id_memrd = v.memrd; id_memwr = v.memwr;
    id_alu_op = v.op;    ex_result = v.exres;
    mem_regwr = v.mwr;   mem_rw = v.mrw;     mem_data = v.mdata;
    wb_regwr  = v.wwr;   wb_rw = v.wrw;      wb_data = v.wdata;
    flush     = v.fl;
  endtask

  task automatic chk_all_zero(input string nm, input int idx);
    chk({nm, "_vld"},   idx, 32'(ex_valid),  32'h0);
    chk({nm, "_opa"},   idx, ex_opa,         32'h0);
    chk({nm, "_opb"},   idx, ex_opb,         32'h0);
    chk({nm, "_imm"},   idx, ex_imm,         32'h0);
    chk({nm, "_rw"},    idx, 32'(ex_rw),     32'h0);
    chk({nm, "_regwr"}, idx, 32'(ex_regwr),  32'h0);
    chk({nm, "_memrd"}, idx, 32'(ex_memrd),  32'h0);
    chk({nm, "_memwr"}, idx, 32'(ex_memwr),  32'h0);
    chk({nm, "_aluop"}, idx, 32'(ex_alu_op), 32'h0);
  endtask

  initial begin
    vec_t v;
    //        vld ra rb ua ub rw busa    busb    imm   rwr mrd mwr op exres    mwr mrw mdata    wwr wrw wdata    fl  stl vld opa      opb
    vt[0]  = mk(1, 1, 2, 1, 1, 7, 5,      6,      'h10, 1,  0,  0,  2, 0,       0,  0,  0,       0,  0,  0,       0,  0,  1,  5,       6);
    vt[1]  = mk(1, 8, 9, 1, 1, 3, 1,      2,      'h11, 1,  0,  0,  1, 0,       0,  0,  0,       0,  0,  0,       0,  0,  1,  1,       2);
    // EX r3 (0xA) beats MEM r3 (0xB) beats WB r3 (0xC)
    vt[2]  = mk(1, 3, 3, 1, 1, 10,'h99,   'h98,   'h12, 0,  0,  0,  3, 'hA,    1,  3,  'hB,     1,  3,  'hC,     0,  0,  1,  'hA,     'hA);
    vt[3]  = mk(1, 3, 3, 1, 1, 11,'h99,   'h98,   'h13, 1,  0,  0,  4, 'hA,    1,  3,  'hB,     1,  3,  'hC,     0,  0,  1,  'hB,     'hB);
    vt[4]  = mk(1, 3, 5, 1, 1, 4, 'h99,   'h55,   'h14, 1,  1,  0,  5, 'hA,    0,  3,  'hB,     1,  3,  'hC,     0,  0,  1,  'hC,     'h55);
    // load r4 now in EX, decode uses r4: one stall, then MEM forwards
    vt[5]  = mk(1, 4, 0, 1, 0, 12,'h111,  'h77,   'h15, 1,  0,  1,  6, 'hDEAD, 0,  0,  0,       0,  0,  0,       0,  1,  0,  0,       0);
    vt[6]  = mk(1, 4, 0, 1, 0, 12,'h111,  'h77,   'h15, 1,  0,  1,  6, 'hDEAD, 1,  4,  'h4444,  1,  0,  'hFFFF,  0,  0,  1,  'h4444,  0);
    vt[7]  = mk(1, 1, 2, 1, 1, 6, 1,      2,      'h16, 1,  1,  0,  7, 0,       0,  0,  0,       0,  0,  0,       0,  0,  1,  1,       2);
    // flush with load-use pending: no stall, bubble
    vt[8]  = mk(1, 6, 0, 1, 0, 13,'h5,    0,      'h17, 1,  0,  1,  8, 0,       0,  0,  0,       0,  0,  0,       1,  0,  0,  0,       0);
    vt[9]  = mk(0, 1, 2, 1, 1, 14,9,      9,      'h18, 1,  0,  1,  9, 0,       0,  0,  0,       0,  0,  0,       0,  0,  0,  0,       0);
    vt[10] = mk(1, 1, 2, 1, 1, 9, 3,      4,      'h19, 1,  1,  0,  1, 0,       0,  0,  0,       0,  0,  0,       0,  0,  1,  3,       4);
    // rb matches the load but is not used: no stall, load result not forwarded
    vt[11] = mk(1, 1, 9, 1, 0, 0, 7,      5,      'h1A, 0,  0,  1,  2, 'hBAD,  0,  0,  0,       0,  0,  0,       0,  0,  1,  7,       5);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 0,      0,      0,    0,  0,  0,  0, 0,       0,  0,  0,       0,  0,  0,       0,  0,  0,  0,       0);

    rst = 1'b1;
    apply(vt[12]);
    #1;
    chk_all_zero("reset", 0);
    chk("reset_stall", 0, 32'(stall_id), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(vt[i]);
      #1;
      chk("stall", i, 32'(stall_id), 32'(vt[i].e_stall));
      @(posedge clk);
      #1;
      chk("vld",   i, 32'(ex_valid),  32'(vt[i].e_vld));
      chk("opa",   i, ex_opa,         vt[i].e_opa);
      chk("opb",   i, ex_opb,         vt[i].e_opb);
      chk("imm",   i, ex_imm,         vt[i].e_vld ? vt[i].imm : 32'h0);
      chk("rw",    i, 32'(ex_rw),     vt[i].e_vld ? 32'(vt[i].rw) : 32'h0);
      chk("regwr", i, 32'(ex_regwr),  32'(vt[i].e_vld & vt[i].regwr));
      chk("memrd", i, 32'(ex_memrd),  32'(vt[i].e_vld & vt[i].memrd));
      chk("memwr", i, 32'(ex_memwr),  32'(vt[i].e_vld & vt[i].memwr));
      chk("aluop", i, 32'(ex_alu_op), vt[i].e_vld ? 32'(vt[i].op) : 32'h0);
    end

    // Asynchronous reset between edges while EX holds a valid instruction.
    @(negedge clk);
    v = mk(1, 2, 3, 1, 1, 5, 'h21, 'h22, 'h30, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h21, 'h22);
    apply(v);
    @(posedge clk);
    #1;
    chk("ar_pre_vld", 0, 32'(ex_valid), 32'h1);
    chk("ar_pre_opa", 0, ex_opa,        32'h21);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("ar_mid", 0);
    @(posedge clk);
    #1;
    chk_all_zero("ar_hold", 0);
    @(negedge clk);
    rst = 1'b0;
    v = mk(1, 7, 0, 1, 1, 8, 'h2A, 'h99, 'h40, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h2A, 0);
    apply(v);
    @(posedge clk);
    #1;
    chk("ar_post_vld",   0, 32'(ex_valid),  32'h1);
    chk("ar_post_opa",   0, ex_opa,         32'h2A);
    chk("ar_post_opb",   0, ex_opb,         32'h0);
    chk("ar_post_imm",   0, ex_imm,         32'h40);
    chk("ar_post_rw",    0, 32'(ex_rw),     32'h8);
    chk("ar_post_regwr", 0, 32'(ex_regwr),  32'h1);
    chk("ar_post_aluop", 0, 32'(ex_alu_op), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
